// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer: state encoding,
// counter widths and the per-state output decode.
package pll_seq_pkg;

  localparam int CNT_W   = 20;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } seq_state_e;

  typedef struct packed {
    logic pll_rst;
    logic core_reset_n;
    logic running;
    logic lock_fail;
  } seq_out_t;

  // Output values are a pure function of the state being entered, so the
  // FSM registers them on the same edge as the state itself.
  function automatic seq_out_t state_outs(seq_state_e s);
    seq_out_t o;
    o = '{pll_rst: 1'b1, core_reset_n: 1'b0, running: 1'b0, lock_fail: 1'b0};
    case (s)
      ST_WAIT_LOCK, ST_STABLE: o.pll_rst = 1'b0;
      ST_RUN: begin
        o.pll_rst      = 1'b0;
        o.core_reset_n = 1'b1;
        o.running      = 1'b1;
      end
      ST_FAIL: o.lock_fail = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [RETRY_W-1:0] sat_inc(logic [RETRY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL control/status bundle between the lock sequencer (master) and the
// PLL wrapper / core reset consumers (slave).
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               relock_req;
  logic               pll_rst;
  logic               core_reset_n;
  logic               running;
  logic               lock_fail;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, core_reset_n, running, lock_fail, retry_cnt
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, core_reset_n, running, lock_fail, retry_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status bits; shared by every
// async status input in the core.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [1:0][WIDTH-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the system PLL in reset, waits for a qualified lock with timeout and
// bounded retries, then releases the downstream core reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                 clk_74a,
  input  logic                 reset_n,
  pll_lock_sequencer_if.master bus
);

  // The counter is loaded with N-1 and the state exits on the edge that sees
  // zero, so a full 2^20 timeout still fits in 20 bits.
  localparam logic [CNT_W-1:0]   RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LD     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LD    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  seq_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_inc;
  seq_out_t           outs;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  assign retry_inc = sat_inc(retry);

  function automatic logic [CNT_W-1:0] load_of(seq_state_e s);
    case (s)
      ST_RESET_HOLD: return RST_LD;
      ST_WAIT_LOCK:  return TO_LD;
      ST_STABLE:     return STB_LD;
      default:       return '0;
    endcase
  endfunction

  // Every state entry reloads the shared counter and the registered outputs.
  task automatic enter(input seq_state_e s);
    state <= s;
    cnt   <= load_of(s);
    outs  <= state_outs(s);
  endtask

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      enter(ST_RESET_HOLD);
      retry <= '0;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        ST_RESET_HOLD: if (cnt == '0) enter(ST_WAIT_LOCK);
        ST_WAIT_LOCK: begin
          // Lock seen on the timeout edge wins; no retry is charged.
          if (locked_s) enter(ST_STABLE);
          else if (cnt == '0) begin
            retry <= retry_inc;
            if (retry_inc == RETRY_LIM) enter(ST_FAIL);
            else                        enter(ST_RESET_HOLD);
          end
        end
        ST_STABLE: begin
          if (!locked_s)      enter(ST_WAIT_LOCK);
          else if (cnt == '0) enter(ST_RUN);
        end
        ST_RUN: if (!locked_s || bus.relock_req) enter(ST_RESET_HOLD);
        ST_FAIL: begin
          if (bus.relock_req) begin
            retry <= '0;
            enter(ST_RESET_HOLD);
          end
        end
        default: enter(ST_RESET_HOLD);
      endcase
    end
  end

  assign bus.pll_rst      = outs.pll_rst;
  assign bus.core_reset_n = outs.core_reset_n;
  assign bus.running      = outs.running;
  assign bus.lock_fail    = outs.lock_fail;
  assign bus.retry_cnt    = retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Table-driven bench for pll_lock_sequencer with small parameters; expected
// observations are queued when a vector is driven and popped when sampled.
module tb_pll_lock_sequencer;

  typedef struct packed {
    logic       pll_rst;
    logic       core_reset_n;
    logic       running;
    logic       lock_fail;
    logic [3:0] retry_cnt;
  } obs_t;

  typedef struct {
    string tag;
    bit    rn;
    bit    lk;
    bit    rq;
    int    n;
    obs_t  e;
  } vec_t;

  logic clk_74a = 1'b0;
  logic reset_n;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_74a = ~clk_74a;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   lat_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t mk(bit pr, bit crn, bit run, bit fl, int rc);
    return {pr, crn, run, fl, 4'(rc)};
  endfunction
  function automatic obs_t hold_o(int r); return mk(1, 0, 0, 0, r); endfunction
  function automatic obs_t wait_o(int r); return mk(0, 0, 0, 0, r); endfunction
  function automatic obs_t run_o(int r);  return mk(0, 1, 1, 0, r); endfunction
  function automatic obs_t fail_o(int r); return mk(1, 0, 0, 1, r); endfunction

  function automatic void add(string tag, bit rn, bit lk, bit rq, int n, obs_t e);
    vec_t v;
    v.tag = tag; v.rn = rn; v.lk = lk; v.rq = rq; v.n = n; v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic check_obs(input string tag);
    obs_t a, e;
    a = {bus.pll_rst, bus.core_reset_n, bus.running, bus.lock_fail, bus.retry_cnt};
    e = exp_q.pop_front();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pll_rst=%b core_reset_n=%b running=%b lock_fail=%b retry_cnt=%0d, expected pll_rst=%b core_reset_n=%b running=%b lock_fail=%b retry_cnt=%0d",
               tag, a.pll_rst, a.core_reset_n, a.running, a.lock_fail, a.retry_cnt,
               e.pll_rst, e.core_reset_n, e.running, e.lock_fail, e.retry_cnt);
    end
  endtask

  task automatic check_int(input string tag, input int act);
    int e;
    e = lat_q.pop_front();
    n_checks++;
    if (act != e) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles, expected %0d", tag, act, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n        = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;

    // clean lock
    add("reset",        0, 0, 0,  2, hold_o(0));
    add("hold",         1, 0, 0,  3, hold_o(0));
    add("hold_end",     1, 0, 0,  1, wait_o(0));
    add("wait",         1, 0, 0,  5, wait_o(0));
    add("lock_lat",     1, 1, 0, 10, wait_o(0));
    add("clean_run",    1, 1, 0,  1, run_o(0));
    // loss of lock in RUN, then relock
    add("loss_sync",    1, 0, 0,  2, run_o(0));
    add("loss_run",     1, 0, 0,  1, hold_o(0));
    add("loss_hold",    1, 0, 0,  3, hold_o(0));
    add("loss_hold_end",1, 0, 0,  1, wait_o(0));
    add("relock_lat",   1, 1, 0, 10, wait_o(0));
    add("relock_run",   1, 1, 0,  1, run_o(0));
    // glitchy lock
    add("g_loss_sync",  1, 0, 0,  2, run_o(0));
    add("g_loss",       1, 0, 0,  1, hold_o(0));
    add("g_hold",       1, 0, 0,  3, hold_o(0));
    add("g_wait",       1, 0, 0,  1, wait_o(0));
    add("glitch_hi",    1, 1, 0,  5, wait_o(0));
    add("glitch_lo",    1, 0, 0,  1, wait_o(0));
    add("glitch_lat",   1, 1, 0, 10, wait_o(0));
    add("glitch_run",   1, 1, 0,  1, run_o(0));
    // relock_req together with locked_s falling, then relock_req in WAIT_LOCK
    add("s_loss_sync",  1, 0, 0,  2, run_o(0));
    add("loss_and_req", 1, 0, 1,  1, hold_o(0));
    add("single_hold",  1, 0, 0,  3, hold_o(0));
    add("single_end",   1, 0, 0,  1, wait_o(0));
    add("req_in_wait",  1, 0, 1,  1, wait_o(0));
    // timeouts into FAIL, then clear
    add("pre_timeout",  1, 0, 0, 30, wait_o(0));
    add("timeout1",     1, 0, 0,  1, hold_o(1));
    add("retry_hold",   1, 0, 0,  3, hold_o(1));
    add("retry_wait",   1, 0, 0,  1, wait_o(1));
    add("pre_timeout2", 1, 0, 0, 31, wait_o(1));
    add("fail",         1, 0, 0,  1, fail_o(2));
    add("fail_stay",    1, 0, 0,  5, fail_o(2));
    add("fail_clear",   1, 0, 1,  1, hold_o(0));
    add("clr_hold",     1, 0, 0,  3, hold_o(0));
    add("clr_wait",     1, 0, 0,  1, wait_o(0));
    // lock arriving on the timeout edge
    add("near_timeout", 1, 0, 0, 29, wait_o(0));
    add("lock_wins",    1, 1, 0,  3, wait_o(0));
    add("lw_stable",    1, 1, 0,  7, wait_o(0));
    add("lw_run",       1, 1, 0,  1, run_o(0));
    // retry_cnt survives RUN, then reset mid-STABLE
    add("r_loss_sync",  1, 0, 0,  2, run_o(0));
    add("r_loss",       1, 0, 0,  1, hold_o(0));
    add("r_hold",       1, 0, 0,  3, hold_o(0));
    add("r_wait",       1, 0, 0,  1, wait_o(0));
    add("r_pre_to",     1, 0, 0, 31, wait_o(0));
    add("r_timeout",    1, 0, 0,  1, hold_o(1));
    add("lock_in_hold", 1, 1, 0,  3, hold_o(1));
    add("r_wait2",      1, 1, 0,  1, wait_o(1));
    add("r_stable",     1, 1, 0,  2, wait_o(1));
    add("r_stable2",    1, 1, 0,  6, wait_o(1));
    add("retry_kept",   1, 1, 0,  1, run_o(1));
    add("req_run",      1, 1, 1,  1, hold_o(1));
    add("req_hold",     1, 1, 0,  3, hold_o(1));
    add("req_wait",     1, 1, 0,  1, wait_o(1));
    add("in_stable",    1, 1, 0,  2, wait_o(1));
    add("mid_reset",    0, 1, 0,  1, hold_o(0));
    add("mr_hold",      1, 1, 0,  3, hold_o(0));
    add("mr_wait",      1, 1, 0,  1, wait_o(0));
    add("mr_stable",    1, 1, 0,  8, wait_o(0));
    add("mr_run",       1, 1, 0,  1, run_o(0));

    foreach (vecs[i]) begin
      reset_n        = vecs[i].rn;
      bus.pll_locked = vecs[i].lk;
      bus.relock_req = vecs[i].rq;
      exp_q.push_back(vecs[i].e);
      @(posedge clk_74a);
      #1 bus.relock_req = 1'b0;
      repeat (vecs[i].n - 1) @(posedge clk_74a);
      @(negedge clk_74a);
      check_obs(vecs[i].tag);
    end

    // Measured latencies from RUN: loss-of-lock, hold width, lock-to-release.
    lat_q.push_back(3);
    bus.pll_locked = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_74a);
      cyc++;
    end while (bus.core_reset_n !== 1'b0 && cyc < 20);
    check_int("loss_latency", cyc);

    lat_q.push_back(4);
    cyc = 0;
    while (bus.pll_rst === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk_74a);
    end
    check_int("pll_rst_width", cyc);

    lat_q.push_back(11);
    bus.pll_locked = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk_74a);
      cyc++;
    end while (bus.core_reset_n !== 1'b1 && cyc < 40);
    check_int("release_latency", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
